ascii_evt_fifo: RTL and testbench
=================================

ASCII_EVT_FIFO -- requirements
Module: ascii_evt_fifo

Interface
REQ-001 Parameter DEPTH, 16, number of FIFO entries; a power of two, 4..64.
REQ-002 Parameter GAP, 27000, minimum clk cycles between successive ds_out pulses (1 ms at 27 MHz) so the LCD/VGA writers settle.
REQ-003 clk  input  1  single system clock (CLOCK_27); all state is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ds_in  input  1  character-done level/strobe from the texter; a rising edge marks one event.
REQ-006 bk_in  input  1  backspace flag, sampled with ds_in.
REQ-007 ascii_in  input  8  character code, sampled with ds_in.
REQ-008 ds_out  output  1  one-cycle pulse to the display modules.
REQ-009 back_sp_out  output  1  backspace flag of the issued entry, valid while ds_out=1.
REQ-010 ascii_out  output  8  character code of the issued entry, valid while ds_out=1.
REQ-011 count  output  7  current occupancy, 0..DEPTH.
REQ-012 full  output  1  high when count==DEPTH.
REQ-013 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-014 Rising-edge detect: push = ds_in & ~ds_q, where ds_q is ds_in registered; a held-high ds_in produces exactly one push.
REQ-015 Push stores the 9-bit entry {bk_in, ascii_in} at the tail on the edge where push=1.
REQ-016 Push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs on the same edge (count unchanged).
REQ-017 Push while full with no same-edge pop is dropped; overflow sets to 1 and stays set until reset.
REQ-018 Read FSM states: IDLE, ISSUE, WAIT.
REQ-019 IDLE -> ISSUE when count>0; otherwise stays in IDLE.
REQ-020 ISSUE lasts one cycle: ds_out=1, outputs carry the head entry, head pops on the exiting edge; ISSUE -> WAIT.
REQ-021 WAIT counts GAP-1 cycles, then -> IDLE; the spacing between ds_out rising edges is therefore >= GAP+1 cycles.
REQ-022 Latency: a push on edge N into an empty FIFO in IDLE gives ds_out=1 in the cycle after edge N+1.
REQ-023 ascii_out and back_sp_out hold their last issued value outside ISSUE; ds_out=0 outside ISSUE.
REQ-024 Pointers wrap modulo DEPTH; count is computed as (push accepted) - (pop), saturating never needed.
REQ-025 Order is strict FIFO; no entry is lost except under REQ-017 (or REQ-030).

Reset
REQ-026 reset=0 asynchronously forces: FSM=IDLE, pointers=0, count=0, full=0, overflow=0, ds_out=0, back_sp_out=0, ascii_out=8'h00, ds_q=0, WAIT counter=0.
REQ-027 Reset mid-WAIT or mid-ISSUE discards all queued entries; no ds_out pulse occurs until a new push after release.
REQ-028 Edge detection starts from ds_q=0, so ds_in=1 at reset release counts as one push.

Configuration
REQ-029 Macro BKSP_MERGE_EN selects backspace merging.
REQ-030 With BKSP_MERGE_EN defined: a push with bk_in=1 when count>=1 and the tail entry has bk=0 removes that tail entry (tail pointer decrements, count-1) instead of enqueuing; exception: if count==1 and that entry is popped on the same edge, the backspace is enqueued normally.
REQ-031 Without BKSP_MERGE_EN: every backspace is enqueued as an ordinary entry under REQ-015..REQ-017.

Verification
REQ-032 Single event: GAP=4, reset released, ds_in rising with ascii_in=8'h41, bk_in=0 -> exactly one ds_out pulse, ascii_out=8'h41, back_sp_out=0, 2 edges after the push; count returns to 0.
REQ-033 Burst: 5 pushes 'A'..'E' on consecutive rising edges of ds_in, GAP=4 -> 5 ds_out pulses in order A..E, rising edges spaced exactly 5 cycles apart.
REQ-034 Overflow: DEPTH=4, GAP=100, 6 fast pushes -> ds_out issues the 1st entry, the FIFO holds the next 4, the 6th is dropped, overflow=1; entries 1..5 are emitted in order.
REQ-035 Held input: ds_in held high for 50 cycles -> exactly one entry is pushed.
REQ-036 Reset mid-drain: 3 entries queued, reset=0 during WAIT -> all outputs are at reset values immediately; after release no ds_out pulse occurs.
REQ-037 BKSP_MERGE_EN defined, GAP=100: push 'H', then 'I' and a backspace while 'H' is in WAIT -> only 'H' is emitted and count=0; with the macro undefined -> 'H', 'I' and the backspace are emitted with back_sp_out=1 on the third pulse.

Source files
------------

// File: rtl/ascii_evt_fifo.sv
// Event FIFO between the texter and the LCD/VGA writers: edge-detects ds_in, queues
// {bk, ascii} entries, and re-issues them as ds_out pulses spaced by at least GAP+1 cycles.
// Optional macro BKSP_MERGE_EN: a backspace cancels a still-queued ordinary character.
module ascii_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int GAP   = 27000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ds_in,
  input  logic       bk_in,
  input  logic [7:0] ascii_in,
  output logic       ds_out,
  output logic       back_sp_out,
  output logic [7:0] ascii_out,
  output logic [6:0] count,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(GAP) + 1;
  localparam logic [6:0]    DEPTH_C   = 7'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(GAP - 2);

  typedef struct packed {
    logic       bk;
    logic [7:0] ch;
  } evt_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  evt_t          mem [DEPTH];
  evt_t          tail, head;
  logic          ds_q;
  logic          push, pop, merge, accept, go;

  assign push = ds_in & ~ds_q;
  assign pop  = (state == ISSUE);
  assign tail = mem[wr_ptr - PTR_ONE];
  assign head = mem[rd_ptr];

`ifdef BKSP_MERGE_EN
  assign merge = push & bk_in & (count != 7'd0) & ~tail.bk & ~((count == 7'd1) & pop);
`else
  assign merge = 1'b0;
`endif

  assign accept = push & ~merge & ((count < DEPTH_C) | pop);
  // Don't start an issue on the edge where a backspace cancels the only entry.
  assign go     = (state == IDLE) & (count != 7'd0) & ~(merge & (count == 7'd1));
  assign full   = (count == DEPTH_C);
  assign ds_out = (state == ISSUE);

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      IDLE:  if (go) state_nx = ISSUE;
      ISSUE: begin
        state_nx    = WAIT;
        wait_cnt_nx = '0;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nx = IDLE;
        else                       wait_cnt_nx = wait_cnt + CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ds_q        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      ascii_out   <= 8'h00;
      back_sp_out <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      ds_q     <= ds_in;
      count    <= count + {6'b0, accept} - {6'b0, pop} - {6'b0, merge};
      if (push & ~merge & ~accept) overflow <= 1'b1;
      if (merge)       wr_ptr <= wr_ptr - PTR_ONE;
      else if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      // Outputs are latched on entry to ISSUE and held until the next issue.
      if (go) begin
        ascii_out   <= head.ch;
        back_sp_out <= head.bk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= '{bk: bk_in, ch: ascii_in};
  end

endmodule

// File: tb/tb_ascii_evt_fifo.sv
// Randomised + directed bench for ascii_evt_fifo against a queue-based reference model.
module tb_ascii_evt_fifo;
  localparam int DEPTH = 4;
  localparam int GAP   = 20;

  logic       clk = 1'b0, reset = 1'b0, ds_in = 1'b0, bk_in = 1'b0;
  logic [7:0] ascii_in = 8'h00;
  logic       ds_out, back_sp_out, full, overflow;
  logic [7:0] ascii_out;
  logic [6:0] count;

  ascii_evt_fifo #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .ds_in(ds_in), .bk_in(bk_in), .ascii_in(ascii_in),
    .ds_out(ds_out), .back_sp_out(back_sp_out), .ascii_out(ascii_out),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0, cyc_no = 0;

  // reference model: queue of entries plus an issue/quiet-time tracker
  logic [8:0] q[$];
  bit         ds_prev, ovf, m_issue;
  int         m_quiet;
  logic [8:0] m_last;
  logic [8:0] log_d[$];
  int         log_t[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  task automatic model_clear();
    q.delete();
    ds_prev = 1'b0; ovf = 1'b0; m_issue = 1'b0; m_quiet = 0; m_last = '0;
  endtask

  task automatic model_edge();
    bit pop, push, merge, go;
    int n;
    n     = q.size();
    pop   = m_issue;
    push  = ds_in && !ds_prev;
    merge = 1'b0;
`ifdef BKSP_MERGE_EN
    if (push && bk_in && n >= 1) if (!q[n-1][8] && !(n == 1 && pop)) merge = 1'b1;
`endif
    go = !m_issue && m_quiet == 0 && n > 0 && !(merge && n == 1);
    if (go) m_last = q[0];
    if (m_issue) m_quiet = GAP - 1;
    else if (m_quiet > 0) m_quiet--;
    m_issue = go;
    if (merge) void'(q.pop_back());
    if (pop) void'(q.pop_front());
    if (push && !merge) begin
      if (n < DEPTH || pop) q.push_back({bk_in, ascii_in});
      else ovf = 1'b1;
    end
    ds_prev = ds_in;
  endtask

  task automatic compare();
    chk("ds_out",      32'(ds_out),      32'(m_issue));
    chk("ascii_out",   32'(ascii_out),   32'(m_last[7:0]));
    chk("back_sp_out", 32'(back_sp_out), 32'(m_last[8]));
    chk("count",       32'(count),       32'(q.size()));
    chk("full",        32'(full),        32'(q.size() == DEPTH));
    chk("overflow",    32'(overflow),    32'(ovf));
    if (ds_out) begin
      log_d.push_back({back_sp_out, ascii_out});
      log_t.push_back(cyc_no);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc_no++;
    if (reset) model_edge();
    else       model_clear();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit d, input bit b, input logic [7:0] c, input int n);
    ds_in = d; bk_in = b; ascii_in = c;
    repeat (n) step();
  endtask

  task automatic push_evt(input bit b, input logic [7:0] c);
    drive(1'b1, b, c, 1);
    drive(1'b0, b, c, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_ds_out",   32'(ds_out),    32'd0);
    chk("rst_count",    32'(count),     32'd0);
    chk("rst_ascii",    32'(ascii_out), 32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    compare();
    repeat (2) step();
    reset = 1'b1;
    log_d.delete();
    log_t.delete();
  endtask

  initial begin
    int t0, k;
    do_reset();

    // single event, latency
    push_evt(1'b0, 8'h41);
    t0 = cyc_no - 1;
    drive(1'b0, 1'b0, 8'h00, 40);
    chk("single_n", 32'(log_d.size()), 32'd1);
    if (log_d.size() > 0) begin
      chk("single_ch",  32'(log_d[0]), 32'h041);
      chk("single_lat", 32'(log_t[0] - t0), 32'd1);
    end

    // burst A..E, exact spacing
    do_reset();
    for (int i = 0; i < 5; i++) push_evt(1'b0, 8'h41 + 8'(i));
    drive(1'b0, 1'b0, 8'h00, 150);
    chk("burst_n", 32'(log_d.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_d.size(); i++) begin
      chk("burst_ch", 32'(log_d[i]), 32'(9'h041 + 9'(i)));
      if (i > 0) chk("burst_gap", 32'(log_t[i] - log_t[i-1]), 32'(GAP + 1));
    end

    // overflow: 6 fast pushes into DEPTH=4
    do_reset();
    for (int i = 0; i < 6; i++) push_evt(1'b0, 8'h61 + 8'(i));
    chk("ovf_set", 32'(overflow), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 150);
    chk("ovf_n", 32'(log_d.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_d.size(); i++)
      chk("ovf_ch", 32'(log_d[i]), 32'(9'h061 + 9'(i)));
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // held-high input
    do_reset();
    drive(1'b1, 1'b0, 8'h5a, 50);
    drive(1'b0, 1'b0, 8'h00, 60);
    chk("held_n", 32'(log_d.size()), 32'd1);

    // ds_in high across reset release counts once
    ds_in = 1'b1; ascii_in = 8'h33;
    do_reset();
    drive(1'b1, 1'b0, 8'h33, 10);
    drive(1'b0, 1'b0, 8'h00, 40);
    chk("rel_n", 32'(log_d.size()), 32'd1);

    // reset mid-drain
    do_reset();
    for (int i = 0; i < 3; i++) push_evt(1'b0, 8'h70 + 8'(i));
    k = 0;
    while (log_d.size() == 0 && k < 100) begin drive(1'b0, 1'b0, 8'h00, 1); k++; end
    chk("drain_first", 32'(log_d.size()), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 3);
    do_reset();
    drive(1'b0, 1'b0, 8'h00, 100);
    chk("drain_none", 32'(log_d.size()), 32'd0);

    // backspace during WAIT
    do_reset();
    push_evt(1'b0, 8'h48);
    drive(1'b0, 1'b0, 8'h00, 3);
    push_evt(1'b0, 8'h49);
    push_evt(1'b1, 8'h08);
    drive(1'b0, 1'b0, 8'h00, 100);
`ifdef BKSP_MERGE_EN
    chk("bksp_n", 32'(log_d.size()), 32'd1);
`else
    chk("bksp_n", 32'(log_d.size()), 32'd3);
    if (log_d.size() == 3) begin
      chk("bksp_i",  32'(log_d[1]), 32'h049);
      chk("bksp_bk", 32'(log_d[2]), 32'h108);
    end
`endif
    chk("bksp_h", 32'(log_d.size() > 0 ? log_d[0] : 9'h0), 32'h048);
    chk("bksp_cnt", 32'(count), 32'd0);

    // random traffic, alternating busy and quiet phases, rare resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      if ((i / 300) % 2 == 1) ds_in = 1'b0;
      else                    ds_in = 1'($urandom_range(0, 1));
      bk_in    = ($urandom_range(0, 3) == 0);
      ascii_in = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
